display_scan_ram: RTL and testbench

DISPLAY_SCAN_RAM -- requirements
Module: display_scan_ram

---
 rtl/display_scan_ram.sv | 155 +++++++++++++++
 tb/tb_display_scan_ram.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ram.sv
// display_scan_ram: byte RAM on a tri-state bus with a button status
// register, a display control register and a row-scanned LED framebuffer.
module display_scan_ram #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned FB_BASE    = 8'h08,
    parameter int unsigned BTN_ADDR   = 8'h00,
    parameter int unsigned CTRL_ADDR  = 8'h01,
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              oe,
    inout  wire  [7:0]        data,
    input  logic [N_BTN-1:0]  btn,
    output logic [ROWS-1:0]   led_row,
    output logic [7:0]        led_col
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PW    = $clog2(SCAN_DIV);
    localparam int unsigned CW    = $clog2(DEB_CYCLES + 1);

    logic [7:0]       r_mem [DEPTH];
    logic [7:0]       r_rdata;
    logic [1:0]       r_ctrl;
    logic [PW-1:0]    r_pre;
    logic [RW-1:0]    r_row;
    logic [ROWS-1:0]  r_led_row;
    logic [7:0]       r_led_col;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_deb;
    logic [N_BTN-1:0] r_flag;
    logic [CW-1:0]    r_cnt [N_BTN];

    logic              w_is_btn;
    logic              w_is_ctrl;
    logic              w_ram_we;
    logic              w_rd_btn;
    logic [N_BTN-1:0]  w_deb_nxt;
    logic [N_BTN-1:0]  w_rise;
    logic [N_BTN-1:0]  w_clr;
    logic [CW-1:0]     w_cnt_nxt [N_BTN];
    logic [7:0]        w_stat;
    logic [7:0]        w_rd_mux;
    logic [7:0]        w_fb;
    logic [ADDR_W-1:0] w_fb_addr;

    assign w_is_btn  = addr == ADDR_W'(BTN_ADDR);
    assign w_is_ctrl = addr == ADDR_W'(CTRL_ADDR);
    assign w_ram_we  = we && !reset && !w_is_btn && !w_is_ctrl;
    assign w_rd_btn  = !we && oe && w_is_btn;
    assign w_clr     = w_rd_btn ? r_flag : '0;
    assign w_rise    = w_deb_nxt & ~r_deb;
    assign w_fb_addr = ADDR_W'(FB_BASE) + ADDR_W'(r_row);
    assign w_fb      = r_mem[w_fb_addr];

    assign data    = (oe && !we && !reset) ? r_rdata : 8'hzz;
    assign led_row = r_led_row;
    assign led_col = r_led_col;

    always_comb begin
        w_stat = '0;
        w_stat[4 +: N_BTN] = r_flag;
        w_stat[0 +: N_BTN] = r_deb;
    end

    // A level is accepted only after DEB_CYCLES consecutive differing clocks.
    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < N_BTN; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    w_deb_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (w_is_btn) begin
            w_rd_mux = w_stat;
        end else if (w_is_ctrl) begin
            w_rd_mux = {6'b0, r_ctrl};
        end else begin
            w_rd_mux = r_mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[addr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata   <= '0;
            r_ctrl    <= 2'b01;
            r_pre     <= '0;
            r_row     <= '0;
            r_led_row <= '0;
            r_led_col <= 8'hFF;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_flag    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (!we) begin
                r_rdata <= w_rd_mux;
            end
            if (we && w_is_ctrl) begin
                r_ctrl <= data[1:0];
            end
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            // A press on the clearing edge survives the clear.
            r_flag <= (r_flag & ~w_clr) | w_rise;
            if (r_pre == PW'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                if (r_row == RW'(ROWS - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            // Row and column both derive from r_row in the same cycle.
            r_led_row <= r_ctrl[0] ? (ROWS'(1) << r_row) : '0;
            if (!r_ctrl[0]) begin
                r_led_col <= 8'hFF;
            end else if (r_ctrl[1]) begin
                r_led_col <= w_fb;
            end else begin
                r_led_col <= ~w_fb;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ram.sv
// tb_display_scan_ram: scoreboard bench for the scanned LED RAM,
// covering bus access, control, debounce and scan sequencing.
module tb_display_scan_ram;
    localparam int SD   = 16;
    localparam int DEB  = 16;
    localparam int ROWS = 8;
    localparam logic [7:0] BTN  = 8'h00;
    localparam logic [7:0] CTRL = 8'h01;
    localparam logic [7:0] FB   = 8'h08;
    localparam logic [7:0] PARK = 8'hF0;

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic       we;
    logic       oe;
    logic [3:0] btn;
    logic [7:0] led_row;
    logic [7:0] led_col;
    logic [7:0] tb_d;
    logic       tb_drv;
    wire  [7:0] data;

    int checks;
    int errors;
    logic [7:0] m [256];
    logic [7:0] exp_q [$];
    logic [7:0] e;

    assign data = tb_drv ? tb_d : 8'hzz;

    display_scan_ram #(
        .SCAN_DIV  (SD),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .oe     (oe),
        .data   (data),
        .btn    (btn),
        .led_row(led_row),
        .led_col(led_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; oe = 1'b0; tb_drv = 1'b0; addr = PARK;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; we = 1'b1; oe = 1'b0; tb_d = d; tb_drv = 1'b1;
        if (a != BTN && a != CTRL) m[a] = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] x);
        tb_drv = 1'b0; we = 1'b0; oe = 1'b1; addr = a;
        exp_q.push_back(x);
    endtask

    task automatic rst_pulse(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rst_pulse(2);
        reset = 1'b1;
        checks++;
        if (led_row !== 8'h00) begin
            errors++;
            $display("FAIL reset_row got=%h exp=00", led_row);
        end
        checks++;
        if (led_col !== 8'hFF) begin
            errors++;
            $display("FAIL reset_col got=%h exp=ff", led_col);
        end
        tick();
        reset = 1'b0;
        rd(CTRL, 8'h01);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL reset_ctrl got=%h exp=%h", data, e);
        end
        rd(BTN, 8'h00);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL reset_btn got=%h exp=%h", data, e);
        end
        idle();
    endtask

    task automatic test_rw();
        logic [7:0] al [14];
        for (int i = 0; i < ROWS; i++) wr(FB + 8'(i), 8'(17 * (i + 1)));
        for (int i = 0; i < 4; i++) wr(8'h80 + 8'(i), 8'($urandom));
        wr(8'h10, 8'h3E);
        wr(8'hFF, 8'hC1);
        for (int i = 0; i < ROWS; i++) al[i] = FB + 8'(i);
        for (int i = 0; i < 4; i++) al[8 + i] = 8'h80 + 8'(i);
        al[12] = 8'h10;
        al[13] = 8'hFF;
        for (int i = 0; i < 14; i++) begin
            rd(al[i], m[al[i]]);
            tick();
            e = exp_q.pop_front(); checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL ram_rd a=%h got=%h exp=%h", al[i], data, e);
            end
        end
        wr(8'h90, 8'hC7);
        rd(8'h90, 8'hC7);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL wr_then_rd got=%h exp=%h", data, e);
        end
        wr(BTN, 8'hFF);
        rd(BTN, 8'h00);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL btn_wr_ignored got=%h exp=%h", data, e);
        end
        idle();
    endtask

    task automatic test_scan();
        int bad;
        int r;
        reset = 1'b1;
        addr = 8'h80; we = 1'b1; tb_d = 8'h77; tb_drv = 1'b1;
        tick();
        idle();
        tick();
        reset = 1'b0;
        bad = 0;
        for (int c = 1; c <= (ROWS + 1) * SD; c++) begin
            tick();
            r = ((c - 1) / SD) % ROWS;
            if (led_row !== 8'(1 << r) || led_col !== ~m[FB + 8'(r)]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL scan_seq bad_cycles=%0d exp=0", bad);
        end
        rd(8'h80, m[8'h80]);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL wr_in_reset got=%h exp=%h", data, e);
        end
        idle();
        wr(FB + 8'd2, 8'h5A);
        rst_pulse(2);
        repeat (2 * SD + 1) tick();
        checks++;
        if (led_row !== 8'h04 || led_col !== 8'hA5) begin
            errors++;
            $display("FAIL row2 got=%h/%h exp=04/a5", led_row, led_col);
        end
        wr(FB + 8'd2, 8'h3C);
        tick();
        checks++;
        if (led_col !== 8'hC3) begin
            errors++;
            $display("FAIL fb_update got=%h exp=c3", led_col);
        end
    endtask

    task automatic test_ctrl();
        wr(CTRL, 8'h03);
        tick();
        checks++;
        if (led_row !== 8'h04 || led_col !== 8'h3C) begin
            errors++;
            $display("FAIL ctrl_inv got=%h/%h exp=04/3c", led_row, led_col);
        end
        rd(CTRL, 8'h03);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL ctrl_rd3 got=%h exp=%h", data, e);
        end
        wr(CTRL, 8'h00);
        tick();
        checks++;
        if (led_row !== 8'h00 || led_col !== 8'hFF) begin
            errors++;
            $display("FAIL ctrl_off got=%h/%h exp=00/ff", led_row, led_col);
        end
        wr(CTRL, 8'hFF);
        rd(CTRL, 8'h03);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL ctrl_mask got=%h exp=%h", data, e);
        end
        wr(CTRL, 8'h01);
    endtask

    task automatic test_btn_press();
        logic [7:0] ex [3];
        btn[1] = 1'b1;
        repeat (2 + DEB + 2) tick();
        ex[0] = 8'h22; ex[1] = 8'h02;
        for (int i = 0; i < 2; i++) begin
            rd(BTN, ex[i]);
            tick();
            e = exp_q.pop_front(); checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL btn_press%0d got=%h exp=%h", i, data, e);
            end
        end
        idle();
        btn[1] = 1'b0;
        repeat (2 + DEB + 2) tick();
        rd(BTN, 8'h00);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL btn_release got=%h exp=%h", data, e);
        end
        idle();
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 100; c++) begin
            btn[0] = ((c / (DEB - 1)) % 2) == 0;
            tick();
        end
        btn[0] = 1'b0;
        repeat (DEB + 4) tick();
        rd(BTN, 8'h00);
        tick();
        e = exp_q.pop_front(); checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL bounce got=%h exp=%h", data, e);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex [3];
        btn[0] = 1'b1;
        repeat (DEB + 1) tick();
        ex[0] = 8'h00; ex[1] = 8'h11; ex[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            rd(BTN, ex[i]);
            tick();
            e = exp_q.pop_front(); checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL same_edge%0d got=%h exp=%h", i, data, e);
            end
        end
        idle();
        btn[0] = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic test_deb_abort();
        logic [7:0] ex [3];
        btn[2] = 1'b1;
        repeat (10) tick();
        rst_pulse(2);
        repeat (DEB) tick();
        ex[0] = 8'h00; ex[1] = 8'h00; ex[2] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            rd(BTN, ex[i]);
            tick();
            e = exp_q.pop_front(); checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL deb_abort%0d got=%h exp=%h", i, data, e);
            end
        end
        idle();
        btn[2] = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        rst_pulse(2);
        repeat (5 * SD + SD / 2) tick();
        checks++;
        if (led_row !== 8'h20) begin
            errors++;
            $display("FAIL row5 got=%h exp=20", led_row);
        end
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if (led_row !== 8'h00 || led_col !== 8'hFF) begin
            errors++;
            $display("FAIL mid_reset got=%h/%h exp=00/ff", led_row, led_col);
        end
        reset = 1'b0;
        bad = 0;
        for (int c = 1; c <= SD; c++) begin
            tick();
            if (led_row !== 8'h01 || led_col !== ~m[FB]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL row0_after bad_cycles=%0d exp=0", bad);
        end
        tick();
        checks++;
        if (led_row !== 8'h02) begin
            errors++;
            $display("FAIL row1_after got=%h exp=02", led_row);
        end
        for (int i = 0; i < ROWS; i++) begin
            rd(FB + 8'(i), m[FB + 8'(i)]);
            tick();
            e = exp_q.pop_front(); checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL ram_kept a=%h got=%h exp=%h", FB + 8'(i), data, e);
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        btn = '0;
        tb_d = '0;
        idle();
        test_reset();
        test_rw();
        test_scan();
        test_ctrl();
        test_btn_press();
        test_bounce();
        test_back_to_back();
        test_deb_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
